// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard producing decode/fetch stall and execute bubble.
// Optional performance counters are enabled by defining HAZ_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned LAT_W   = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              issue_valid_i,
  input  logic              issue_wen_i,
  input  logic [REG_AW-1:0] issue_dst_i,
  input  logic [LAT_W-1:0]  issue_lat_i,
  input  logic [REG_AW-1:0] src_a_i,
  input  logic [REG_AW-1:0] src_b_i,
  input  logic              src_a_use_i,
  input  logic              src_b_use_i,
  input  logic              freeze_i,
  input  logic              flush_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_e_o,
  output logic              issue_ack_o,
  output logic              busy_o,
  output logic [REG_AW:0]   pending_o
`ifdef HAZ_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       raw_events_o
`endif
);

  localparam int unsigned PW = REG_AW + 1;

  logic [LAT_W-1:0] cnt [REG_NUM];
  logic [LAT_W-1:0] nxt [REG_NUM];
  logic [LAT_W-1:0] cnt_a, cnt_b;
  logic [LAT_W-1:0] dec;
  logic             raw_a, raw_b, raw_any;
  logic             stall;
  logic             wr_en;
  logic [PW-1:0]    pend;

  // Look up source countdowns; register 0 and out-of-range indices read as zero
  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    for (int r = 1; r < int'(REG_NUM); r++) begin
      if (src_a_i == REG_AW'(r)) cnt_a = cnt[r];
      if (src_b_i == REG_AW'(r)) cnt_b = cnt[r];
    end
  end

  assign raw_a   = src_a_use_i & (cnt_a != '0);
  assign raw_b   = src_b_use_i & (cnt_b != '0);
  assign raw_any = issue_valid_i & (raw_a | raw_b);

  // Stall/bubble/ack decisions; held quiet while reset is asserted
  always_comb begin
    stall       = resetn & issue_valid_i & (raw_a | raw_b | freeze_i) & ~flush_i;
    stall_d_o   = stall;
    stall_f_o   = stall;
    flush_e_o   = resetn & issue_valid_i & (raw_a | raw_b) & ~freeze_i & ~flush_i;
    issue_ack_o = resetn & issue_valid_i & ~stall & ~flush_i;
  end

  assign wr_en = issue_ack_o & issue_wen_i;

  // Next countdowns: decrement unless frozen, then merge accepted write keeping the longer wait
  always_comb begin
    dec = '0;
    for (int r = 0; r < int'(REG_NUM); r++) begin
      dec = (!freeze_i && cnt[r] != '0) ? cnt[r] - LAT_W'(1) : cnt[r];
      nxt[r] = dec;
      if (wr_en && r != 0 && issue_dst_i == REG_AW'(r) && issue_lat_i > dec)
        nxt[r] = issue_lat_i;
      if (r == 0)
        nxt[r] = '0;
    end
  end

  // Countdown state; flush discards all in-flight producers
  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(REG_NUM); r++) begin
      if (!resetn || flush_i) cnt[r] <= '0;
      else                    cnt[r] <= nxt[r];
    end
  end

  // Count registers with an outstanding wait
  always_comb begin
    pend = '0;
    for (int r = 0; r < int'(REG_NUM); r++) begin
      if (cnt[r] != '0) pend = pend + PW'(1);
    end
  end

  assign pending_o = pend;
  assign busy_o    = (pend != '0);

`ifdef HAZ_SCOREBOARD_PERF_EN
  logic raw_q;

  // Stall-cycle and RAW-onset counters; survive flush, wrap naturally
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles_o <= '0;
      raw_events_o   <= '0;
      raw_q          <= 1'b0;
    end else begin
      raw_q <= raw_any;
      if (stall_d_o)          stall_cycles_o <= stall_cycles_o + 32'd1;
      if (raw_any && !raw_q)  raw_events_o   <= raw_events_o + 32'd1;
    end
  end
`else
  logic unused_raw;
  assign unused_raw = raw_any;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (REG_NUM reduced to 24 to reach out-of-range indices).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic       issue_valid_i, issue_wen_i;
  logic [4:0] issue_dst_i;
  logic [2:0] issue_lat_i;
  logic [4:0] src_a_i, src_b_i;
  logic       src_a_use_i, src_b_use_i;
  logic       freeze_i, flush_i;
  logic       stall_f_o, stall_d_o, flush_e_o, issue_ack_o, busy_o;
  logic [5:0] pending_o;
`ifdef HAZ_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles_o, raw_events_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.REG_NUM(24), .REG_AW(5), .LAT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid_i(issue_valid_i), .issue_wen_i(issue_wen_i),
    .issue_dst_i(issue_dst_i), .issue_lat_i(issue_lat_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i),
    .src_a_use_i(src_a_use_i), .src_b_use_i(src_b_use_i),
    .freeze_i(freeze_i), .flush_i(flush_i),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .flush_e_o(flush_e_o),
    .issue_ack_o(issue_ack_o), .busy_o(busy_o), .pending_o(pending_o)
`ifdef HAZ_SCOREBOARD_PERF_EN
    , .stall_cycles_o(stall_cycles_o), .raw_events_o(raw_events_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic w, input logic [4:0] d, input logic [2:0] l,
                     input logic [4:0] a, input logic au, input logic [4:0] b, input logic bu,
                     input logic fz, input logic fl);
    issue_valid_i = v; issue_wen_i = w; issue_dst_i = d; issue_lat_i = l;
    src_a_i = a; src_a_use_i = au; src_b_i = b; src_b_use_i = bu;
    freeze_i = fz; flush_i = fl;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {stall_f, stall_d, flush_e, ack, busy, pending}
  task automatic exp_o(input string tag, input logic sd, input logic fe, input logic ack,
                       input logic bsy, input logic [5:0] pend);
    #1;
    chk(tag, 32'({stall_f_o, stall_d_o, flush_e_o, issue_ack_o, busy_o, pending_o}),
        32'({sd, sd, fe, ack, bsy, pend}));
  endtask

  initial begin
    resetn = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with random activity
    for (int i = 0; i < 2; i++) begin
      drv(1, 1'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk("reset_ctl", 32'({stall_f_o, stall_d_o, flush_e_o, issue_ack_o}), 32'd0);
      cyc();
    end
    resetn = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_o("reset_release", 0, 0, 0, 0, 6'd0);

    // Load-use with latency 1, then latency 0
    drv(1, 1, 8, 1, 0, 0, 0, 0, 0, 0); exp_o("lu_issue", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 0, 0, 0, 8, 1, 0, 0, 0, 0); exp_o("lu_stall", 1, 1, 0, 1, 6'd1); cyc();
    exp_o("lu_release", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 1, 8, 0, 0, 0, 0, 0, 0, 0); exp_o("lu0_issue", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 0, 0, 0, 8, 1, 0, 0, 0, 0); exp_o("lu0_nostall", 0, 0, 1, 0, 6'd0); cyc();

    // Divider freeze extends the wait
    drv(1, 1, 3, 2, 0, 0, 0, 0, 0, 0); exp_o("frz_issue", 0, 0, 1, 0, 6'd0); cyc();
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 0, 3, 1, 0, 0, 1, 0); exp_o("frz_hold", 1, 0, 0, 1, 6'd1); cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drv(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); exp_o("frz_count", 1, 1, 0, 1, 6'd1); cyc();
    end
    exp_o("frz_release", 0, 0, 1, 0, 6'd0); cyc();
`ifdef HAZ_SCOREBOARD_PERF_EN
    chk("perf_stall_cycles", stall_cycles_o, 32'd7);
    chk("perf_raw_events", raw_events_o, 32'd2);
`endif

    // WAW keeps the longer wait
    drv(1, 1, 5, 4, 0, 0, 0, 0, 0, 0); exp_o("waw_first", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 1, 5, 1, 0, 0, 0, 0, 0, 0); exp_o("waw_second", 0, 0, 1, 1, 6'd1); cyc();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0, 0, 0, 5, 1, 0, 0); exp_o("waw_stall", 1, 1, 0, 1, 6'd1); cyc();
    end
    exp_o("waw_release", 0, 0, 1, 0, 6'd0); cyc();

    // Flush mid-wait discards everything including the flushed issue
    drv(1, 1, 9, 5, 0, 0, 0, 0, 0, 0); exp_o("fl_issue9", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 1, 7, 2, 0, 0, 0, 0, 0, 0); exp_o("fl_issue7", 0, 0, 1, 1, 6'd1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_o("fl_idle", 0, 0, 0, 1, 6'd2); cyc();
    drv(1, 1, 10, 3, 9, 1, 0, 0, 0, 1); exp_o("fl_flush", 0, 0, 0, 1, 6'd2); cyc();
    drv(1, 0, 0, 0, 10, 1, 9, 1, 0, 0); exp_o("fl_after", 0, 0, 1, 0, 6'd0); cyc();

    // Register zero and out-of-range indices
    drv(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); exp_o("r0_issue", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); exp_o("r0_use", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 1, 28, 5, 0, 0, 0, 0, 0, 0); exp_o("oor_issue", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 0, 0, 0, 28, 1, 0, 1, 0, 0); exp_o("oor_use", 0, 0, 1, 0, 6'd0); cyc();

    // Unused sources, stalled writes and non-writing issues do not track
    drv(1, 1, 12, 3, 0, 0, 0, 0, 0, 0); exp_o("use_issue", 0, 0, 1, 0, 6'd0); cyc();
    drv(1, 0, 0, 0, 12, 0, 12, 0, 0, 0); exp_o("use_unused", 0, 0, 1, 1, 6'd1); cyc();
    drv(1, 1, 14, 6, 12, 1, 0, 0, 0, 0); exp_o("use_stall_wr", 1, 1, 0, 1, 6'd1); cyc();
    drv(1, 0, 13, 4, 0, 0, 0, 0, 0, 0); exp_o("use_nowen", 0, 0, 1, 1, 6'd1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_o("use_drained", 0, 0, 0, 0, 6'd0); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
